reg_writeback_queue: RTL and testbench

//  Write-side master for the 8x16 register file: buffers results from execute/memory stages
//  and issues them one per clock on the file's write port (RegWrite/WriteRegister/WriteData).
//  It keeps per-register pending bits so decode can stall on RAW hazards.
//  It sits between the multi-cycle datapath writeback mux and the register file.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo.sv | 84 ++++++++
 rtl/reg_writeback_queue.sv | 111 +++++++++++
 tb/tb_reg_writeback_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants, FSM states and the queued-entry record for the register-file writeback queue.
package wb_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef enum logic [1:0] {EMPTY, ACTIVE, STALLED, DRAIN} wb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order storage for pending register writes: pointers, occupancy, per-slot valid view and,
// when WB_FORWARD_EN is defined, the youngest-matching-entry lookup used for decode bypass.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic                   head_valid,
  output logic [CNT_W-1:0]       count,
  output logic [DEPTH-1:0]       slot_valid,
  output logic [DEPTH*ADDR_W-1:0] slot_rd
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0]      fwd_addr,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data
`endif
);
  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head       = head_valid ? mem_q[rd_ptr_q] : '0;

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] age;
    assign age                          = PTR_W'(gi) - rd_ptr_q;
    assign slot_valid[gi]               = (CNT_W'(age) < count_q);
    assign slot_rd[gi*ADDR_W +: ADDR_W] = mem_q[gi].rd;
  end

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (mem_q[fwd_idx].rd == fwd_addr) && (fwd_addr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_q[fwd_idx].data;
      end
    end
  end
`endif
endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback queue in front of the 8x16 register file: handshake, r0 filtering, FSM with drain,
// and RAW pending mask. Define WB_FORWARD_EN to add the fwd_addr/fwd_hit/fwd_data bypass lookup.
module reg_writeback_queue
  import wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_rd,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                wb_stall,
  input  logic                drain_req,
  output logic                drain_done,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   WriteRegister,
  output logic [DATA_W-1:0]   WriteData,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [CNT_W-1:0]    count
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0]   fwd_addr,
  output logic                fwd_hit,
  output logic [DATA_W-1:0]   fwd_data
`endif
);
  wb_state_t                state_q, state_d;
  logic                     done_sent_q, done_sent_d;
  logic                     push, pop, head_valid;
  wb_entry_t                head;
  logic [DEPTH-1:0]         slot_valid;
  logic [DEPTH*ADDR_W-1:0]  slot_rd;
  logic [NUM_REGS-1:0]      slot_onehot [DEPTH];

  assign in_ready = (count < CNT_W'(DEPTH)) && (state_q != DRAIN);
  // Writes to r0 complete the handshake but are dropped here.
  assign push     = in_valid && in_ready && (in_rd != '0);
  assign pop      = head_valid && !wb_stall;

  assign RegWrite      = pop;
  assign WriteRegister = head.rd;
  assign WriteData     = head.data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (Clk),
    .rst        (Reset),
    .push       (push),
    .push_entry ('{rd: in_rd, data: in_data}),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (count),
    .slot_valid (slot_valid),
    .slot_rd    (slot_rd)
`ifdef WB_FORWARD_EN
    ,
    .fwd_addr   (fwd_addr),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
`endif
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
    assign slot_onehot[gi] = slot_valid[gi] ? (NUM_REGS'(1) << slot_rd[gi*ADDR_W +: ADDR_W]) : '0;
  end

  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < DEPTH; k++) pending_mask = pending_mask | slot_onehot[k];
  end

  // done_sent remembers that the drain pulse fired while drain_req is still held.
  always_comb begin
    state_d     = state_q;
    done_sent_d = 1'b0;
    drain_done  = 1'b0;
    case (state_q)
      EMPTY:   if (push) state_d = ACTIVE;
      ACTIVE: begin
        if (wb_stall) state_d = STALLED;
        else if (pop && (count == CNT_W'(1)) && !push) state_d = EMPTY;
      end
      STALLED: if (!wb_stall) state_d = ACTIVE;
      DRAIN: begin
        if (count == '0) begin
          drain_done  = !done_sent_q;
          done_sent_d = 1'b1;
          if (!drain_req) state_d = EMPTY;
        end else begin
          done_sent_d = done_sent_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (drain_req && (state_q != DRAIN)) state_d = DRAIN;
    if (state_d != DRAIN) done_sent_d = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= EMPTY;
      done_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_sent_q <= done_sent_d;
    end
  end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: a per-cycle vector table plus drain and reset sequences.
module tb_reg_writeback_queue;
  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_rd;
  logic [15:0] in_data;
  logic        wb_stall;
  logic        drain_req;
  logic        drain_done;
  logic        RegWrite;
  logic [2:0]  WriteRegister;
  logic [15:0] WriteData;
  logic [7:0]  pending_mask;
  logic [2:0]  count;
`ifdef WB_FORWARD_EN
  logic [2:0]  fwd_addr;
  logic        fwd_hit;
  logic [15:0] fwd_data;
`endif

  int checks = 0;
  int passes = 0;

  always #5 Clk = ~Clk;

  reg_writeback_queue dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_data       (in_data),
    .wb_stall      (wb_stall),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .pending_mask  (pending_mask),
    .count         (count)
`ifdef WB_FORWARD_EN
    ,
    .fwd_addr      (fwd_addr),
    .fwd_hit       (fwd_hit),
    .fwd_data      (fwd_data)
`endif
  );

  typedef struct {
    logic        v;
    logic [2:0]  rd;
    logic [15:0] d;
    logic        stall;
    logic [2:0]  fa;
    logic        rw;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic [7:0]  mask;
    logic [2:0]  cnt;
    logic        rdy;
    logic        fh;
    logic [15:0] fd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [2:0] rd, logic [15:0] d, logic stall, logic [2:0] fa,
                              logic rw, logic [2:0] wr, logic [15:0] wd, logic [7:0] mask,
                              logic [2:0] cnt, logic rdy, logic fh, logic [15:0] fd);
    vec_t r;
    r.v = v; r.rd = rd; r.d = d; r.stall = stall; r.fa = fa;
    r.rw = rw; r.wr = wr; r.wd = wd; r.mask = mask; r.cnt = cnt; r.rdy = rdy;
    r.fh = fh; r.fd = fd;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(logic v, logic [2:0] rd, logic [15:0] d, logic stall, logic drain);
    in_valid  = v;
    in_rd     = rd;
    in_data   = d;
    wb_stall  = stall;
    drain_req = drain;
  endtask

  function automatic logic [32:0] snap();
    return {RegWrite, WriteRegister, WriteData, pending_mask, count, in_ready, drain_done};
  endfunction

  initial begin
    logic [18:0] writes[$];
    int          pulses;
    logic [2:0]  cnt_at_done;
    logic        ready_seen;
    logic        any_write;

    // in, rd, data, stall, fwd_addr | RegWrite, WriteRegister, WriteData, mask, count, in_ready, fwd_hit, fwd_data
    vecs.push_back(mk(1, 3, 16'h1234, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 3, 16'h1234, 8'h08, 1, 1, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0));
    vecs.push_back(mk(1, 0, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0));
    vecs.push_back(mk(1, 1, 16'h0011, 1, 0, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0));
    vecs.push_back(mk(1, 2, 16'h0022, 1, 0, 0, 1, 16'h0011, 8'h02, 1, 1, 0, 16'h0));
    vecs.push_back(mk(1, 4, 16'h0044, 1, 0, 0, 1, 16'h0011, 8'h06, 2, 1, 0, 16'h0));
    vecs.push_back(mk(1, 5, 16'h0055, 1, 0, 0, 1, 16'h0011, 8'h16, 3, 1, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 1, 16'h0011, 8'h36, 4, 0, 0, 16'h0));
    vecs.push_back(mk(1, 7, 16'h0077, 1, 0, 0, 1, 16'h0011, 8'h36, 4, 0, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 1, 16'h0011, 8'h36, 4, 0, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 2, 16'h0022, 8'h34, 3, 1, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 4, 16'h0044, 8'h30, 2, 1, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 5, 16'h0055, 8'h20, 1, 1, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0));
    vecs.push_back(mk(1, 2, 16'h00A2, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0));
    vecs.push_back(mk(1, 3, 16'h00A3, 0, 0, 1, 2, 16'h00A2, 8'h04, 1, 1, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 3, 16'h00A3, 8'h08, 1, 1, 0, 16'h0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0));
    vecs.push_back(mk(1, 6, 16'h000A, 1, 6, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0));
    vecs.push_back(mk(1, 6, 16'h000B, 1, 6, 0, 6, 16'h000A, 8'h40, 1, 1, 1, 16'hA));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 6, 0, 6, 16'h000A, 8'h40, 2, 1, 1, 16'hB));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 6, 1, 6, 16'h000A, 8'h40, 2, 1, 1, 16'hB));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 6, 1, 6, 16'h000B, 8'h40, 1, 1, 1, 16'hB));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 6, 0, 0, 16'h0000, 8'h00, 0, 1, 0, 16'h0));

    Reset = 1'b1;
    drive(0, 0, 0, 0, 0);
`ifdef WB_FORWARD_EN
    fwd_addr = '0;
`endif
    @(negedge Clk);
    check("reset_state", 64'({RegWrite, WriteRegister, WriteData, pending_mask, count, drain_done}), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);
    @(negedge Clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].rd, vecs[i].d, vecs[i].stall, 0);
`ifdef WB_FORWARD_EN
      fwd_addr = vecs[i].fa;
`endif
      #1;
      $display("row %0d: in_valid=%0b rd=%0d stall=%0b -> RegWrite=%0b WriteRegister=%0d WriteData=%h mask=%h count=%0d in_ready=%0b",
               i, in_valid, in_rd, wb_stall, RegWrite, WriteRegister, WriteData, pending_mask, count, in_ready);
      check($sformatf("row%0d", i), 64'(snap()),
            64'({vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].mask, vecs[i].cnt, vecs[i].rdy, 1'b0}));
`ifdef WB_FORWARD_EN
      check($sformatf("row%0d_fwd", i), 64'({fwd_hit, fwd_data}), 64'({vecs[i].fh, vecs[i].fd}));
`endif
      @(negedge Clk);
    end

    // Drain with three queued entries and a producer pushing throughout.
    drive(1, 1, 16'h0101, 1, 0); @(negedge Clk);
    drive(1, 2, 16'h0202, 1, 0); @(negedge Clk);
    drive(1, 3, 16'h0303, 1, 0); @(negedge Clk);
    drive(0, 0, 16'h0000, 0, 1);
    pulses = 0; cnt_at_done = 3'h7; ready_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (RegWrite) writes.push_back({WriteRegister, WriteData});
      if (drain_done) begin pulses++; cnt_at_done = count; end
      if (c > 0 && in_ready) ready_seen = 1'b1;
      $display("drain cycle %0d: RegWrite=%0b WriteRegister=%0d drain_done=%0b in_ready=%0b count=%0d",
               c, RegWrite, WriteRegister, drain_done, in_ready, count);
      @(negedge Clk);
      if (c == 0) drive(1, 7, 16'h0777, 0, 1);
    end
    check("drain_writes", 64'(writes.size()), 64'd3);
    if (writes.size() == 3) begin
      check("drain_w0", 64'(writes[0]), 64'({3'd1, 16'h0101}));
      check("drain_w1", 64'(writes[1]), 64'({3'd2, 16'h0202}));
      check("drain_w2", 64'(writes[2]), 64'({3'd3, 16'h0303}));
    end
    check("drain_pulses", 64'(pulses), 64'd1);
    check("drain_count_at_done", 64'(cnt_at_done), 64'd0);
    check("drain_ready_low", 64'(ready_seen), 64'd0);
    drive(0, 0, 16'h0000, 0, 0);
    @(negedge Clk);
    #1;
    $display("post drain: in_ready=%0b count=%0d RegWrite=%0b", in_ready, count, RegWrite);
    check("post_drain", 64'({in_ready, count, RegWrite}), 64'({1'b1, 3'd0, 1'b0}));
    @(negedge Clk);

    // Reset while two entries wait behind a stall.
    drive(1, 4, 16'h0444, 1, 0); @(negedge Clk);
    drive(1, 5, 16'h0555, 1, 0); @(negedge Clk);
    drive(0, 0, 16'h0000, 1, 0);
    #1;
    check("pre_reset_count", 64'(count), 64'd2);
    Reset = 1'b1;
    drive(0, 0, 16'h0000, 0, 0);
    #1;
    $display("mid-stall reset: RegWrite=%0b count=%0d mask=%h", RegWrite, count, pending_mask);
    check("async_reset", 64'({RegWrite, count, pending_mask}), 64'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    any_write = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (RegWrite || count != 0) any_write = 1'b1;
      @(negedge Clk);
    end
    check("no_stale_write", 64'(any_write), 64'd0);
    #1;
    check("ready_after_mid_reset", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
